i2c_bus_monitor: RTL

//  Passive I2C bus reader. Samples raw SDA/SCL and never drives either line.

---
 rtl/i2c_bus_monitor_if.sv | 31 +++
 rtl/i2c_bus_monitor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_monitor_if.sv
// rtl/i2c_bus_monitor_if.sv - I2C bus monitor signal bundle
// Purpose: groups the raw SDA/SCL taps and the decoded record outputs.
// Ports (signals):
//   sda_in, scl_in   raw bus lines (async to clk)
//   valid            1-cycle record strobe
//   rw, chip_addr, reg_addr, data, nbytes, ack_err, truncated  record fields
//   busy             transaction in progress (START..STOP)
// Modports: master = bus/stimulus side, slave = monitor side.
interface i2c_bus_monitor_if;
  logic        sda_in;
  logic        scl_in;
  logic        valid;
  logic        rw;
  logic [6:0]  chip_addr;
  logic [7:0]  reg_addr;
  logic [15:0] data;
  logic [2:0]  nbytes;
  logic        ack_err;
  logic        truncated;
  logic        busy;

  modport master (
    output sda_in, scl_in,
    input  valid, rw, chip_addr, reg_addr, data, nbytes, ack_err, truncated, busy
  );

  modport slave (
    input  sda_in, scl_in,
    output valid, rw, chip_addr, reg_addr, data, nbytes, ack_err, truncated, busy
  );
endinterface

// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - passive I2C register-protocol decoder
// Purpose: samples raw SDA/SCL, never drives them, and emits one record per
//   transaction (7-bit chip address, 8-bit register, 16-bit data MSB first).
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    i2c_bus_monitor_if.slave: sda_in/scl_in in; valid, rw, chip_addr,
//          reg_addr, data, nbytes, ack_err, truncated, busy out
// Parameters: SYNC_STAGES (>=2) synchronizer depth; FILTER_LEN glitch filter
//   length, present only when I2C_BUS_MONITOR_GLITCH_FILTER_EN is defined.
// Macro: I2C_BUS_MONITOR_GLITCH_FILTER_EN enables the SDA/SCL glitch filter.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
`ifdef I2C_BUS_MONITOR_GLITCH_FILTER_EN
  , parameter int FILTER_LEN = 4
`endif
) (
  input  logic              clk,
  input  logic              reset,
  i2c_bus_monitor_if.slave  bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_REG  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_EMIT = 3'd4;

  // Synchronizers reset to 1 (idle bus level) so reset release makes no edge.
  logic [SYNC_STAGES-1:0] sda_sync, scl_sync;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_sync <= '1;
      scl_sync <= '1;
    end else begin
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
    end
  end

  logic sda_s, scl_s;
`ifdef I2C_BUS_MONITOR_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN) + 1;
  logic [FCW-1:0] sda_fcnt, scl_fcnt;
  logic           sda_f, scl_f;
  // Output follows the input only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_f    <= 1'b1;
      scl_f    <= 1'b1;
      sda_fcnt <= '0;
      scl_fcnt <= '0;
    end else begin
      if (sda_sync[SYNC_STAGES-1] == sda_f) begin
        sda_fcnt <= '0;
      end else if (sda_fcnt == FCW'(FILTER_LEN - 1)) begin
        sda_f    <= sda_sync[SYNC_STAGES-1];
        sda_fcnt <= '0;
      end else begin
        sda_fcnt <= sda_fcnt + 1'b1;
      end
      if (scl_sync[SYNC_STAGES-1] == scl_f) begin
        scl_fcnt <= '0;
      end else if (scl_fcnt == FCW'(FILTER_LEN - 1)) begin
        scl_f    <= scl_sync[SYNC_STAGES-1];
        scl_fcnt <= '0;
      end else begin
        scl_fcnt <= scl_fcnt + 1'b1;
      end
    end
  end
  assign sda_s = sda_f;
  assign scl_s = scl_f;
`else
  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign scl_s = scl_sync[SYNC_STAGES-1];
`endif

  logic sda_d, scl_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_d <= 1'b1;
      scl_d <= 1'b1;
    end else begin
      sda_d <= sda_s;
      scl_d <= scl_s;
    end
  end

  // START/STOP need SCL high on both samples, so an SDA edge coinciding with
  // an SCL edge is never mistaken for a bus condition.
  logic start_ev, stop_ev, rise_ev, fall_ev;
  assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
  assign rise_ev  = scl_s & ~scl_d;
  assign fall_ev  = ~scl_s & scl_d;

  logic [2:0]  state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        bit_pend, bit_val;
  logic        w_rw, w_ack_err, pend_nack;
  logic [6:0]  w_chip;
  logic [7:0]  w_reg;
  logic [15:0] w_data;
  logic [2:0]  w_nbytes;
  logic        busy_q;

  logic active, cont_sr, emit, start_new;
  assign active    = (state == ST_ADDR) || (state == ST_REG) || (state == ST_DATA);
  // Write of only a register pointer followed by Sr: the read that follows
  // belongs to the same record.
  assign cont_sr   = (state == ST_DATA) && (w_nbytes == 3'd0) && !w_rw && (bit_cnt == 4'd0);
  assign emit      = active && (stop_ev || (start_ev && !cont_sr));
  assign start_new = start_ev && (!active || !cont_sr);

  // A bit is captured on the SCL rise but only committed on the SCL fall:
  // the rise that precedes a STOP/Sr is then dropped instead of being counted
  // as a data bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      bit_pend  <= 1'b0;
      bit_val   <= 1'b0;
      w_rw      <= 1'b0;
      w_ack_err <= 1'b0;
      pend_nack <= 1'b0;
      w_chip    <= '0;
      w_reg     <= '0;
      w_data    <= '0;
      w_nbytes  <= '0;
      busy_q    <= 1'b0;
    end else begin
      if (start_ev)                busy_q <= 1'b1;
      else if (stop_ev && active)  busy_q <= 1'b0;

      if (stop_ev && active) begin
        state    <= ST_EMIT;
        bit_pend <= 1'b0;
      end else if (start_ev) begin
        state    <= ST_ADDR;
        bit_cnt  <= '0;
        bit_pend <= 1'b0;
        if (start_new) begin
          w_rw      <= 1'b0;
          w_ack_err <= 1'b0;
          pend_nack <= 1'b0;
          w_chip    <= '0;
          w_reg     <= '0;
          w_data    <= '0;
          w_nbytes  <= '0;
        end
      end else if (state == ST_EMIT) begin
        state <= ST_IDLE;
      end else if (active && rise_ev) begin
        bit_pend <= 1'b1;
        bit_val  <= sda_s;
      end else if (active && fall_ev && bit_pend) begin
        bit_pend <= 1'b0;
        if (bit_cnt != 4'd8) begin
          shift   <= {shift[6:0], bit_val};
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          // ACK slot: bit_val is the ACK level (0=ACK), shift holds the byte.
          bit_cnt <= '0;
          case (state)
            ST_ADDR: begin
              w_chip <= shift[7:1];
              w_rw   <= shift[0];
              if (bit_val) w_ack_err <= 1'b1;
              state  <= shift[0] ? ST_DATA : ST_REG;
            end
            ST_REG: begin
              w_reg <= shift;
              if (bit_val) w_ack_err <= 1'b1;
              state <= ST_DATA;
            end
            default: begin
              w_data <= {w_data[7:0], shift};
              if (w_nbytes != 3'd7) w_nbytes <= w_nbytes + 1'b1;
              if (!w_rw) begin
                if (bit_val) w_ack_err <= 1'b1;
              end else begin
                // A read NACK is only legal on the final byte.
                if (pend_nack) w_ack_err <= 1'b1;
                pend_nack <= bit_val;
              end
            end
          endcase
        end
      end
    end
  end

  logic        valid_q, rw_q, ack_err_q, trunc_q;
  logic [6:0]  chip_q;
  logic [7:0]  reg_q;
  logic [15:0] data_q;
  logic [2:0]  nbytes_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      rw_q      <= 1'b0;
      ack_err_q <= 1'b0;
      trunc_q   <= 1'b0;
      chip_q    <= '0;
      reg_q     <= '0;
      data_q    <= '0;
      nbytes_q  <= '0;
    end else begin
      valid_q <= emit;
      if (emit) begin
        rw_q      <= w_rw;
        ack_err_q <= w_ack_err;
        trunc_q   <= (bit_cnt != 4'd0);
        chip_q    <= w_chip;
        reg_q     <= w_reg;
        data_q    <= w_data;
        nbytes_q  <= w_nbytes;
      end
    end
  end

  assign bus.valid     = valid_q;
  assign bus.rw        = rw_q;
  assign bus.chip_addr = chip_q;
  assign bus.reg_addr  = reg_q;
  assign bus.data      = data_q;
  assign bus.nbytes    = nbytes_q;
  assign bus.ack_err   = ack_err_q;
  assign bus.truncated = trunc_q;
  assign bus.busy      = busy_q;

endmodule
